// File: rtl/mem_stage_if.sv
// mem_stage_if: byte-wide shared RAM port between the memory stage and the
// arbiter/RAM side. Also carries the pipeline op encoding shared by users.

`ifndef MEM_STAGE_OPS_DEFINED
`define MEM_STAGE_OPS_DEFINED
`define OpLen 4
`define NOP 4'd0
`define LB  4'd1
`define LH  4'd2
`define LW  4'd3
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd6
`define SH  4'd7
`define SW  4'd8
`define ADD 4'd9
`endif

interface mem_stage_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  modport master (output mem_req, mem_a, mem_wr, mem_dout, input mem_gnt, mem_din);
  modport slave  (input mem_req, mem_a, mem_wr, mem_dout, output mem_gnt, mem_din);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Runs byte/half/word loads and stores over a shared byte-wide RAM port,
// stalling upstream until the access completes; other ops pass straight through.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no RAM access, misalign flag in DONE) instead of running them bytewise.

`ifndef MEM_STAGE_OPS_DEFINED
`define MEM_STAGE_OPS_DEFINED
`define OpLen 4
`define NOP 4'd0
`define LB  4'd1
`define LH  4'd2
`define LW  4'd3
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd6
`define SH  4'd7
`define SW  4'd8
`define ADD 4'd9
`endif

module mem_stage #(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`OpLen-1:0] op_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       rd_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              mem_stall,
  output logic              misalign,
  mem_stage_if.master       bus
);

  typedef enum logic [2:0] {IDLE, GNT, ACCESS, DRAIN, DONE} state_e;

  state_e      state_q;
  logic [31:0] base_q;
  logic [31:0] data_q;      // store data, or load bytes as they arrive
  logic [4:0]  rd_q;
  logic        store_q;
  logic        signed_q;
  logic [1:0]  last_q;      // index of the final byte (n-1)
  logic [1:0]  idx_q;
  logic [1:0]  drain_q;
  logic        misal_q;
  logic [31:0] a_q;
  logic        wr_q;
  logic [7:0]  dout_q;
  // Tags of issued load bytes travelling alongside the RAM read latency.
  logic        pend_vld_q  [RD_LAT];
  logic [1:0]  pend_slot_q [RD_LAT];

  logic        is_mem;
  logic        is_store;
  logic        is_signed;
  logic [1:0]  last_idx;
  logic        misal_det;
  logic [31:0] load_val;

  // Decode the incoming op into access size, direction and extension.
  always_comb begin
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    last_idx  = 2'd0;
    case (op_i)
      `LB:  begin is_mem = 1'b1; is_signed = 1'b1; end
      `LBU: begin is_mem = 1'b1; end
      `SB:  begin is_mem = 1'b1; is_store = 1'b1; end
      `LH:  begin is_mem = 1'b1; is_signed = 1'b1; last_idx = 2'd1; end
      `LHU: begin is_mem = 1'b1; last_idx = 2'd1; end
      `SH:  begin is_mem = 1'b1; is_store = 1'b1; last_idx = 2'd1; end
      `LW:  begin is_mem = 1'b1; last_idx = 2'd3; end
      `SW:  begin is_mem = 1'b1; is_store = 1'b1; last_idx = 2'd3; end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal_det = is_mem && (((last_idx == 2'd1) && mem_addr_i[0]) ||
                                ((last_idx == 2'd3) && (mem_addr_i[1:0] != 2'b00)));
`else
  assign misal_det = 1'b0;
`endif

  // Sign- or zero-extend the assembled load value to 32 bits.
  always_comb begin
    case (last_q)
      2'd0:    load_val = {{24{signed_q & data_q[7]}}, data_q[7:0]};
      2'd1:    load_val = {{16{signed_q & data_q[15]}}, data_q[15:0]};
      default: load_val = data_q;
    endcase
  end

  // Access FSM: latch the op, wait for grant, stream bytes, drain reads, report.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      last_q   <= '0;
      idx_q    <= '0;
      drain_q  <= '0;
      misal_q  <= 1'b0;
      a_q      <= '0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pend_vld_q[k]  <= 1'b0;
        pend_slot_q[k] <= '0;
      end
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pend_vld_q[k]  <= pend_vld_q[k-1];
        pend_slot_q[k] <= pend_slot_q[k-1];
      end
      pend_vld_q[0]  <= (state_q == ACCESS) && !store_q;
      pend_slot_q[0] <= idx_q;
      if (pend_vld_q[RD_LAT-1]) begin
        data_q[{pend_slot_q[RD_LAT-1], 3'b000} +: 8] <= bus.mem_din;
      end

      unique case (state_q)
        IDLE: begin
          if (is_mem) begin
            base_q   <= mem_addr_i;
            data_q   <= is_store ? rd_data_i : 32'd0;
            rd_q     <= rd_addr_i;
            store_q  <= is_store;
            signed_q <= is_signed;
            last_q   <= last_idx;
            misal_q  <= misal_det;
            state_q  <= misal_det ? DONE : GNT;
          end
        end
        GNT: begin
          if (bus.mem_gnt) begin
            state_q <= ACCESS;
            idx_q   <= 2'd0;
            a_q     <= base_q;
            wr_q    <= store_q;
            dout_q  <= store_q ? data_q[7:0] : 8'd0;
          end
        end
        ACCESS: begin
          if (idx_q == last_q) begin
            a_q     <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            drain_q <= 2'd0;
            state_q <= store_q ? DONE : DRAIN;
          end else begin
            idx_q  <= idx_q + 2'd1;
            a_q    <= base_q + 32'(idx_q) + 32'd1;
            dout_q <= store_q ? data_q[{idx_q + 2'd1, 3'b000} +: 8] : 8'd0;
          end
        end
        DRAIN: begin
          if (drain_q == 2'(RD_LAT - 1)) state_q <= DONE;
          else                           drain_q <= drain_q + 2'd1;
        end
        DONE: begin
          state_q <= IDLE;
          misal_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline-facing outputs: passthrough/detect in IDLE, result in DONE.
  always_comb begin
    rd_data_o   = '0;
    rd_addr_o   = '0;
    mem_stall   = 1'b0;
    bus.mem_req = 1'b0;
    misalign    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst) begin
          if (is_mem) begin
            mem_stall   = 1'b1;
            bus.mem_req = !misal_det;
          end else begin
            rd_data_o = rd_data_i;
            rd_addr_o = rd_addr_i;
          end
        end
      end
      GNT, ACCESS, DRAIN: begin
        mem_stall   = 1'b1;
        bus.mem_req = 1'b1;
      end
      DONE: begin
        misalign = misal_q;
        if (!misal_q && !store_q) begin
          rd_data_o = load_val;
          rd_addr_o = rd_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_a    = a_q;
  assign bus.mem_wr   = wr_q;
  assign bus.mem_dout = dout_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Driver issues ops and pushes
// expected results from a byte-array memory model; monitors compare results
// and RAM writes as the DUT produces them.

`ifndef MEM_STAGE_OPS_DEFINED
`define MEM_STAGE_OPS_DEFINED
`define OpLen 4
`define NOP 4'd0
`define LB  4'd1
`define LH  4'd2
`define LW  4'd3
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd6
`define SH  4'd7
`define SW  4'd8
`define ADD 4'd9
`endif

module tb_mem_stage;
  localparam int RD_LAT = 1;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [`OpLen-1:0] op_i = `ADD;
  logic [31:0]       mem_addr_i = '0;
  logic [31:0]       rd_data_i = 32'h0000_1234;
  logic [4:0]        rd_addr_i = 5'd7;
  logic [31:0]       rd_data_o;
  logic [4:0]        rd_addr_o;
  logic              mem_stall;
  logic              misalign;

  mem_stage_if bus ();

  mem_stage #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .mem_addr_i(mem_addr_i),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_addr_o(rd_addr_o), .mem_stall(mem_stall), .misalign(misalign),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        mis;
    int          stalls;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wexp_q[$];
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] refm [logic [31:0]];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return 8'(a * 32'd37 + (a >> 8));
  endfunction
  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_byte(a);
  endfunction

  function automatic int nbytes(logic [3:0] op);
    case (op)
      `LB, `LBU, `SB: return 1;
      `LH, `LHU, `SH: return 2;
      `LW, `SW:       return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference: what the op should do to memory and what writeback it produces.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input int dly);
    exp_t e;
    int n = nbytes(op);
    bit st = (op == `SB) || (op == `SH) || (op == `SW);
    bit sx = (op == `LB) || (op == `LH);
    logic [31:0] v = 0;
    e.data = 0; e.addr = 0; e.mis = 0; e.stalls = 0;
    if (n == 0) begin
      e.data = d; e.addr = rd;
    end else if (TRAP && (a % n) != 0) begin
      e.mis = 1; e.stalls = 1;
    end else if (st) begin
      for (int i = 0; i < n; i++) begin
        refm[a + 32'(i)] = d[8*i +: 8];
        wexp_q.push_back(wexp_t'{a: a + 32'(i), d: d[8*i +: 8]});
      end
      e.stalls = 2 + dly + n;
    end else begin
      for (int i = 0; i < n; i++) v = v + (32'(ref_rd(a + 32'(i))) << (8 * i));
      if (sx && v[8*n-1]) v = v - (32'd1 << (8 * n));
      e.data = v; e.addr = rd;
      e.stalls = 2 + dly + n + RD_LAT;
    end
    exp_q.push_back(e);
  endtask

  // Arbiter: grant after the requested number of extra GNT cycles, held while req.
  int next_dly = 0;
  int gcnt = 0;
  bit req_seen = 0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (!req_seen) begin
        req_seen = 1;
        gcnt = next_dly;
      end else if (gcnt == 0) bus.mem_gnt = 1'b1;
      else gcnt--;
    end else begin
      req_seen = 0;
      bus.mem_gnt = 1'b0;
    end
  end

  // RAM: RD_LAT-cycle read pipe, byte writes checked against expected writes.
  logic [31:0] hist[$];
  int wcount = 0;
  always @(negedge clk) begin : ram_model
    wexp_t w;
    hist.push_front(bus.mem_a);
    if (hist.size() > RD_LAT + 1) void'(hist.pop_back());
    bus.mem_din = (hist.size() > RD_LAT) ? ram_rd(hist[RD_LAT]) : 8'h00;
    if (bus.mem_wr === 1'b1) begin
      chk("wr_gnt", 32'(bus.mem_gnt), 1);
      chk("wr_expected", 32'(wexp_q.size() != 0), 1);
      if (wexp_q.size() != 0) begin
        w = wexp_q.pop_front();
        chk("wr_addr", bus.mem_a, w.a);
        chk("wr_data", 32'(bus.mem_dout), 32'(w.d));
      end
      ram[bus.mem_a] = bus.mem_dout;
      wcount++;
    end
  end

  // Result monitor: DONE (stall falling) or same-cycle passthrough of non-mem ops.
  bit prev_stall = 0;
  int scnt = 0;
  int ev_cnt = 0;
  bit active = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      prev_stall = 0;
      scnt = 0;
    end else begin
      if (mem_stall) scnt++;
      else if (prev_stall || (active && nbytes(op_i) == 0)) begin
        chk("exp_available", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_data_o", rd_data_o, e.data);
          chk("rd_addr_o", 32'(rd_addr_o), 32'(e.addr));
          chk("misalign", 32'(misalign), 32'(e.mis));
          chk("stall_cycles", 32'(scnt), 32'(e.stalls));
          chk("req_low_at_result", 32'(bus.mem_req), 0);
        end
        scnt = 0;
        ev_cnt++;
      end
      prev_stall = mem_stall;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input int dly);
    int start;
    bit done = 0;
    @(posedge clk); #1;
    model(op, a, d, rd, dly);
    op_i = op; mem_addr_i = a; rd_data_i = d; rd_addr_i = rd;
    next_dly = dly; active = 1;
    start = ev_cnt;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); #1;
      if (ev_cnt != start) done = 1;
    end
    chk("txn_complete", 32'(done), 1);
    $display("txn op=%0d addr=%h data=%h rd=%0d gnt_dly=%0d", op, a, d, rd, dly);
    op_i = `NOP; rd_data_i = '0; rd_addr_i = '0; active = 0;
  endtask

  task automatic reset_mid_store();
    int w0;
    bit seen = 0;
    @(posedge clk); #1;
    wexp_q.push_back(wexp_t'{a: 32'h300, d: 8'hD4});
    wexp_q.push_back(wexp_t'{a: 32'h301, d: 8'hC3});
    refm[32'h300] = 8'hD4;
    refm[32'h301] = 8'hC3;
    op_i = `SW; mem_addr_i = 32'h300; rd_data_i = 32'hA1B2C3D4; rd_addr_i = 5'd4;
    next_dly = 0; active = 1;
    w0 = wcount;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk); #1;
      if (wcount == w0 + 2) seen = 1;
    end
    chk("rst_two_writes", 32'(seen), 1);
    rst = 0; op_i = `NOP; active = 0;
    @(negedge clk);
    chk("rst_abort_wr", 32'(bus.mem_wr), 0);
    chk("rst_abort_stall", 32'(mem_stall), 0);
    chk("rst_abort_req", 32'(bus.mem_req), 0);
    @(posedge clk); #1;
    rst = 1;
    $display("txn reset during SW at 00000300 byte 1");
  endtask

  initial begin
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h80] = 8'h80;  ram[32'h81] = 8'h7F;
    foreach (ram[k]) refm[k] = ram[k];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_data", rd_data_o, 0);
    chk("reset_rd_addr", 32'(rd_addr_o), 0);
    chk("reset_stall", 32'(mem_stall), 0);
    chk("reset_req", 32'(bus.mem_req), 0);
    chk("reset_wr", 32'(bus.mem_wr), 0);
    chk("reset_a", bus.mem_a, 0);
    chk("reset_misalign", 32'(misalign), 0);
    @(posedge clk); #1;
    rst = 1; op_i = `NOP; rd_data_i = '0; rd_addr_i = '0;

    issue(`LW,  32'h100, 32'h0, 5'd5, 0);
    issue(`LB,  32'h80,  32'h0, 5'd1, 0);
    issue(`LBU, 32'h80,  32'h0, 5'd2, 0);
    issue(`LH,  32'h80,  32'h0, 5'd6, 1);
    issue(`ADD, 32'h0,   32'h55, 5'd3, 0);
    issue(`SH,  32'h202, 32'hDEADBEEF, 5'd9, 0);
    issue(`SW,  32'h210, 32'h01020304, 5'd8, 3);
    issue(`SW,  32'hFFFFFFFE, 32'hCAFEF00D, 5'd10, 1);
    issue(`LW,  32'hFFFFFFFE, 32'h0, 5'd11, 2);
    issue(`LW,  32'h101, 32'h0, 5'd12, 0);
    issue(`LHU, 32'h203, 32'h0, 5'd0, 0);
    reset_mid_store();

    for (int t = 0; t < 60; t++) begin
      logic [3:0] op = 4'($urandom_range(0, 12));
      logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                   : 32'h200 + 32'($urandom_range(0, 31));
      issue(op, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("wexp_q_drained", 32'(wexp_q.size()), 0);
    chk("no_rollback_302", 32'(ram_rd(32'h302)), 32'(init_byte(32'h302)));
    chk("no_rollback_303", 32'(ram_rd(32'h303)), 32'(init_byte(32'h303)));
    foreach (refm[k]) chk("ram_final", 32'(ram_rd(k)), 32'(refm[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
